// File: rtl/latent_param_head_if.sv
// latent_param_head_if
//   Bundles the streaming input beat, the result handshake and the status
//   outputs of latent_param_head.
//   slave  : the head itself (consumes beats, produces mean/vare)
//   master : the producer of beats / consumer of results
//   Signals:
//     in_valid/in_ready/in_last, in_x/in_wm/in_wv : input beat stream
//     mean/vare/out_valid/out_ready               : result handshake
//     len_err                                     : sticky over-length flag
//     sat_flag (LATENT_SAT_FLAG_EN only)          : result was clipped
interface latent_param_head_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic signed [DATA_W-1:0] in_x;
    logic signed [DATA_W-1:0] in_wm;
    logic signed [DATA_W-1:0] in_wv;
    logic signed [DATA_W-1:0] mean;
    logic signed [DATA_W-1:0] vare;
    logic                     out_valid;
    logic                     out_ready;
    logic                     len_err;
`ifdef LATENT_SAT_FLAG_EN
    logic                     sat_flag;

    modport slave (
        input  in_valid, in_last, in_x, in_wm, in_wv, out_ready,
        output in_ready, mean, vare, out_valid, len_err, sat_flag
    );
    modport master (
        output in_valid, in_last, in_x, in_wm, in_wv, out_ready,
        input  in_ready, mean, vare, out_valid, len_err, sat_flag
    );
`else
    modport slave (
        input  in_valid, in_last, in_x, in_wm, in_wv, out_ready,
        output in_ready, mean, vare, out_valid, len_err
    );
    modport master (
        output in_valid, in_last, in_x, in_wm, in_wv, out_ready,
        input  in_ready, mean, vare, out_valid, len_err
    );
`endif
endinterface

// File: rtl/latent_param_head.sv
// latent_param_head
//   Encoder output stage of the VAE latent path. Streams a hidden vector one
//   element per beat, accumulates x*wm and x*wv, adds the biases, saturates
//   both to signed Q8.8 and clamps the variance to be non-negative.
//   Optional feature macro: LATENT_SAT_FLAG_EN adds bus.sat_flag.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous active-low reset
//     bus   : latent_param_head_if.slave (beat stream, result handshake,
//             len_err, optional sat_flag)
module latent_param_head #(
    parameter int                       DATA_W  = 16,
    parameter int                       FRAC_W  = 8,
    parameter int                       ACC_W   = 40,
    parameter int                       MAX_LEN = 256,
    parameter logic signed [DATA_W-1:0] BIAS_M  = 16'sd0,
    parameter logic signed [DATA_W-1:0] BIAS_V  = 16'sd0
) (
    input logic            clk,
    input logic            reset,
    latent_param_head_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam logic signed [ACC_W-1:0] Q_MAX =
        $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] Q_MIN =
        $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

    typedef enum logic [1:0] {IDLE, ACC, FINAL, HOLD} state_t;

    state_t                   state, state_nx;
    logic                     rdy_en;
    logic                     beat;
    logic                     at_max;
    logic [CNT_W-1:0]         count;
    logic signed [ACC_W-1:0]  acc_m, acc_v;
    logic signed [PROD_W-1:0] prod_m, prod_v;
    logic signed [ACC_W-1:0]  prod_m_x, prod_v_x;
    logic signed [DATA_W-1:0] sat_m, sat_v;
    logic signed [DATA_W-1:0] mean_q, vare_q;
    logic                     out_valid_q;
    logic                     len_err_q;

    // Rescale to Q8.8 (floor shift) and add the bias at accumulator width.
    function automatic logic signed [ACC_W-1:0] scale_q(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] bias
    );
        return (acc >>> FRAC_W) + ACC_W'(bias);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_q(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] bias
    );
        logic signed [ACC_W-1:0] r;
        r = scale_q(acc, bias);
        if (r > Q_MAX)      return Q_MAX[DATA_W-1:0];
        else if (r < Q_MIN) return Q_MIN[DATA_W-1:0];
        else                return r[DATA_W-1:0];
    endfunction

`ifdef LATENT_SAT_FLAG_EN
    function automatic logic clip_q(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] bias
    );
        logic signed [ACC_W-1:0] r;
        r = scale_q(acc, bias);
        return (r > Q_MAX) || (r < Q_MIN);
    endfunction

    logic sat_flag_q;
    assign bus.sat_flag = sat_flag_q;
`endif

    assign beat     = bus.in_valid & bus.in_ready;
    assign prod_m   = PROD_W'(bus.in_x) * PROD_W'(bus.in_wm);
    assign prod_v   = PROD_W'(bus.in_x) * PROD_W'(bus.in_wv);
    assign prod_m_x = {{(ACC_W-PROD_W){prod_m[PROD_W-1]}}, prod_m};
    assign prod_v_x = {{(ACC_W-PROD_W){prod_v[PROD_W-1]}}, prod_v};
    // count holds the beats already taken, so this beat fills the vector.
    assign at_max   = (count + CNT_W'(1)) == CNT_W'(MAX_LEN);
    assign sat_m    = sat_q(acc_m, BIAS_M);
    assign sat_v    = sat_q(acc_v, BIAS_V);

    assign bus.mean      = mean_q;
    assign bus.vare      = vare_q;
    assign bus.out_valid = out_valid_q;
    assign bus.len_err   = len_err_q;

    // Keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ACC: begin
                if (beat) begin
                    if (bus.in_last || at_max) state_nx = FINAL;
                    else                       state_nx = ACC;
                end
            end
            FINAL:   state_nx = HOLD;
            HOLD:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = rdy_en && ((state == IDLE) || (state == ACC));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_m       <= '0;
            acc_v       <= '0;
            count       <= '0;
            mean_q      <= '0;
            vare_q      <= '0;
            out_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
`ifdef LATENT_SAT_FLAG_EN
            sat_flag_q  <= 1'b0;
`endif
        end else begin
            case (state)
                // acc and count are zero whenever the FSM sits in IDLE, so
                // the first beat's load and later accumulation share one path.
                IDLE, ACC: begin
                    if (beat) begin
                        acc_m <= acc_m + prod_m_x;
                        acc_v <= acc_v + prod_v_x;
                        count <= count + CNT_W'(1);
                        if (at_max && !bus.in_last) len_err_q <= 1'b1;
                    end
                end
                FINAL: begin
                    mean_q      <= sat_m;
                    vare_q      <= sat_v[DATA_W-1] ? '0 : sat_v;
                    out_valid_q <= 1'b1;
`ifdef LATENT_SAT_FLAG_EN
                    sat_flag_q  <= clip_q(acc_m, BIAS_M) | clip_q(acc_v, BIAS_V)
                                 | sat_v[DATA_W-1];
`endif
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_m       <= '0;
                        acc_v       <= '0;
                        count       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_latent_param_head.sv
module tb_latent_param_head;
    localparam int               ML = 4;
    localparam logic signed [15:0] BM = 16'sh0080;
    localparam logic signed [15:0] BV = -16'sd16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    latent_param_head_if #(.DATA_W(16)) bus ();

    latent_param_head #(
        .DATA_W(16), .FRAC_W(8), .ACC_W(40), .MAX_LEN(ML),
        .BIAS_M(BM), .BIAS_V(BV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int mean;
        int vare;
        bit lerr;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   px[$], pm[$], pv[$];
    bit   model_lerr = 0;
    bit   rnd_ready = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: floor(sum/256) + bias, clip to Q8.8, vare floored at 0.
    function automatic longint floor256(input longint s);
        if (s >= 0) return s / 256;
        else        return -((-s + 255) / 256);
    endfunction

    task automatic finalize();
        longint sm = 0, sv = 0, rm, rv;
        exp_t e;
        e.sat = 0;
        foreach (px[i]) begin
            sm += longint'(px[i]) * longint'(pm[i]);
            sv += longint'(px[i]) * longint'(pv[i]);
        end
        rm = floor256(sm) + longint'(BM);
        rv = floor256(sv) + longint'(BV);
        if (rm > 32767)       begin rm = 32767;  e.sat = 1; end
        else if (rm < -32768) begin rm = -32768; e.sat = 1; end
        if (rv > 32767)       begin rv = 32767;  e.sat = 1; end
        else if (rv < -32768) begin rv = -32768; e.sat = 1; end
        if (rv < 0)           begin rv = 0;      e.sat = 1; end
        e.mean = int'(rm);
        e.vare = int'(rv);
        e.lerr = model_lerr;
        exp_q.push_back(e);
        px.delete(); pm.delete(); pv.delete();
    endtask

    task automatic model_beat(input int x, input int wm, input int wv, input bit last);
        px.push_back(x); pm.push_back(wm); pv.push_back(wv);
        if (last || px.size() == ML) begin
            if (!last) model_lerr = 1;
            finalize();
        end
    endtask

    // Offers one beat; cyc returns the number of clock edges until it was taken.
    task automatic send_beat(input int x, input int wm, input int wv, input bit last,
                             output int cyc);
        bit acc_ok = 0;
        bit rdy;
        bus.in_valid = 1'b1;
        bus.in_x     = 16'(x);
        bus.in_wm    = 16'(wm);
        bus.in_wv    = 16'(wv);
        bus.in_last  = last;
        cyc = 0;
        while (!acc_ok && cyc < 100) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            cyc++;
            if (rdy) acc_ok = 1;
        end
        #1;
        bus.in_valid = 1'b0;
        if (acc_ok) model_beat(x, wm, wv, last);
        else chk("accept_timeout", 0, 1);
    endtask

    function automatic int rnd_val(input bit wide);
        if (wide) return int'($urandom_range(0, 65535)) - 32768;
        else      return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    task automatic send_rand_vec(input int n, input bit with_last);
        int cyc;
        bit wide;
        wide = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < n; i++)
            send_beat(rnd_val(wide), rnd_val(wide), rnd_val(wide),
                      with_last && (i == n - 1), cyc);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Random downstream backpressure while enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every result handshake and checks
    // that a result waiting on out_ready does not change.
    initial begin
        logic signed [15:0] hm, hv;
        bit held = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid) begin
                if (held) begin
                    chk("hold_mean", bus.mean, hm);
                    chk("hold_vare", bus.vare, hv);
                end
                if (bus.out_ready) begin
                    held = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mean", int'(bus.mean), e.mean);
                        chk("vare", int'(bus.vare), e.vare);
                        chk("len_err", bus.len_err, e.lerr);
`ifdef LATENT_SAT_FLAG_EN
                        chk("sat_flag", bus.sat_flag, e.sat);
`endif
                    end
                end else begin
                    held = 1;
                    hm = bus.mean;
                    hv = bus.vare;
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        int cyc;
        int n;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_x      = '0;
        bus.in_wm     = '0;
        bus.in_wv     = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mean", bus.mean, 0);
        chk("rst_vare", bus.vare, 0);
        chk("rst_len_err", bus.len_err, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("in_ready_before_clk", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_release", bus.in_ready, 1);

        // Single beat, held until out_ready
        send_beat(16'sh0100, 16'sh0200, 16'sh0080, 1, cyc);
        @(negedge clk);
        chk("final_no_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("valid_after_final", bus.out_valid, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain();

        // Three beats with mean bias
        send_beat(16'sh0100, 16'sh0100, 16'sh0040, 0, cyc);
        send_beat(16'sh0100, 16'sh0100, 16'sh0040, 0, cyc);
        chk("mid_vector_accept", cyc, 1);
        send_beat(16'sh0100, -256, 16'sh0040, 1, cyc);
        wait_drain();

        // Saturation and variance clamp
        for (int i = 0; i < 4; i++)
            send_beat(32767, 32767, -32768, i == 3, cyc);
        wait_drain();

        // Backpressure: result waits, next beat is not consumed
        send_beat(16'sh0300, 16'sh0100, 16'sh0200, 1, cyc);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 16'sh0010;
        bus.in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_beat(16'sh0010, 16'sh0400, -16'sh0400, 1, cyc);
        chk("bp_accept_latency", cyc, 2);
        wait_drain();

        // Length error: five beats without in_last
        chk("len_err_clear", bus.len_err, 0);
        for (int i = 0; i < 4; i++)
            send_beat(16'sh0100 + i, 16'sh0020, 16'sh0030, 0, cyc);
        send_beat(16'sh0200, 16'sh0100, 16'sh0100, 0, cyc);
        chk("overlen_restart_latency", cyc, 3);
        send_beat(16'sh0100, 16'sh0100, 16'sh0100, 1, cyc);
        wait_drain();
        chk("len_err_sticky", bus.len_err, 1);

        // Randomized vectors with random backpressure
        rnd_ready = 1;
        for (int v = 0; v < 30; v++)
            send_rand_vec(int'($urandom_range(1, 6)), $urandom_range(0, 4) != 0);
        send_rand_vec(1, 1);
        wait_drain();
        rnd_ready = 0;
        @(posedge clk);
        #1;

        // Reset while a result is held
        bus.out_ready = 1'b0;
        send_beat(16'sh0100, 16'sh0100, 16'sh0100, 1, cyc);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_before_reset", bus.out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_mean", bus.mean, 0);
        chk("mid_rst_vare", bus.vare, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_len_err", bus.len_err, 0);
`ifdef LATENT_SAT_FLAG_EN
        chk("mid_rst_sat_flag", bus.sat_flag, 0);
`endif
        exp_q.delete();
        px.delete(); pm.delete(); pv.delete();
        model_lerr = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        send_rand_vec(3, 1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
